// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: PC register, IF/ID pipeline register and stall watchdog for the fetch stage.
// Optional perf counters (Stall_Cycles, Flush_Count) enabled by defining IF_PERF_CNT_EN.
`default_nettype none

module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        IF_Flush,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic [31:0] Instr_IF,
  output logic [31:0] PC_IF,
  output logic [31:0] Instr_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic        Stall_Timeout,
  output logic [1:0]  Fetch_State
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] Stall_Cycles,
  output logic [31:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_TIMEOUT = 2'd2
  } fetch_state_e;

  localparam logic [7:0] C_MAX_STALL = 8'(MAX_STALL);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         valid_q, valid_d;
  logic [7:0]   cnt_q, cnt_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  pc_sel;
  logic [8:0]   cnt_inc;

  assign pc_plus4 = pc_q + 32'd4;
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

  // Jump outranks branch; low two bits are always cleared on the selected target.
  always_comb begin
    pc_sel = pc_plus4;
    if (Jump) begin
      pc_sel = Jump_Target;
    end else if (Branch_Taken) begin
      pc_sel = Branch_Target;
    end
    pc_d = PCWrite ? (pc_sel & ~32'h3) : pc_q;
  end

  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (IF_Flush) begin
      instr_d = 32'h0;
      pcp4_d  = 32'h0;
      valid_d = 1'b0;
    end else if (IFID_Write) begin
      instr_d = Instr_IF;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // Watchdog trips on the stall cycle whose increment would hit MAX_STALL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (PCWrite) begin
      cnt_d = 8'h00;
    end else if (cnt_q != C_MAX_STALL) begin
      cnt_d = cnt_inc[7:0];
    end
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (PCWrite) begin
          state_d = ST_RUN;
        end else if (cnt_inc >= {1'b0, C_MAX_STALL}) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'h00;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcp4_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign PC_IF         = pc_q;
  assign Instr_ID      = instr_q;
  assign PCPlus4_ID    = pcp4_q;
  assign Valid_ID      = valid_q;
  assign Stall_Timeout = (state_q == ST_TIMEOUT);
  assign Fetch_State   = state_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cyc_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (!PCWrite) begin
        stall_cyc_q <= stall_cyc_q + 32'd1;
      end
      if (IF_Flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign Stall_Cycles = stall_cyc_q;
  assign Flush_Count  = flush_cnt_q;
`endif

endmodule

`default_nettype wire
